// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the cache line fill controller:
//   ADDR_W_DEF / LINE_W_DEF : default byte-address and cache-line widths
//   IDX_W                   : width of the RAM word/line index buses
//   CNT_W                   : width of the memory latency down-counter
//   fill_state_t            : controller FSM states (IDLE, WB, FILL, RESP)
//   lat_load()              : counter reload value for a given latency
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int LINE_W_DEF = 128;
    localparam int IDX_W      = 20;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } fill_state_t;

    // The counter reaches zero on the last of 'lat' cycles, so it starts at lat-1.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_fill_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_fill_ctrl_if
// Cache-side request/response bundle of the line fill controller.
//   req_valid/req_ready   : miss request handshake
//   req_addr              : line address to fill (bits [3:0] ignored)
//   req_wb                : a dirty victim must be written back first
//   req_wb_addr/_data     : victim line address and data
//   resp_valid/resp_ready : fill response handshake
//   resp_data/resp_addr   : filled line and its line-aligned address
// Modports: master = cache side, slave = fill controller.
// ---------------------------------------------------------------------------
interface mem_fill_ctrl_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wb;
    logic [ADDR_W-1:0] req_wb_addr;
    logic [LINE_W-1:0] req_wb_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_data;
    logic [ADDR_W-1:0] resp_addr;

    modport master (
        output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr
    );

    modport slave (
        input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr
    );

endinterface

// File: rtl/mem_lat_counter.sv
// ---------------------------------------------------------------------------
// mem_lat_counter
// Down-counter timing how long the RAM address/data is held.
//   clk      : clock
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   zero     : count is zero (last cycle of the current RAM access)
// The count stops at zero rather than wrapping.
// ---------------------------------------------------------------------------
module mem_lat_counter
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_fill_ctrl.sv
// ---------------------------------------------------------------------------
// mem_fill_ctrl
// Cache line fill controller: accepts a miss request, optionally writes the
// dirty victim back to RAM, reads the requested line, and presents it to the
// cache until consumed.
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous active-high reset
//   cache          : mem_fill_ctrl_if.slave request/response bundle
//   data_requested : RAM read word index ((req_addr >> 2) with [1:0] cleared)
//   where_to_write : RAM write line index (req_wb_addr >> 4)
//   data_to_write  : RAM write data (victim line)
//   write_to_mem   : RAM write enable, one-cycle pulse at the end of WB
//   data_returned  : RAM read data, sampled on the last FILL cycle
// Optional build macro MEM_FILL_STATS_EN adds 16-bit saturating outputs
// fill_count / wb_count counting completed FILL and WB phases.
// ---------------------------------------------------------------------------
module mem_fill_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_fill_ctrl_if.slave    cache,
    output logic [IDX_W-1:0]  data_requested,
    output logic [IDX_W-1:0]  where_to_write,
    output logic [LINE_W-1:0] data_to_write,
    output logic              write_to_mem,
    input  logic [LINE_W-1:0] data_returned
`ifdef MEM_FILL_STATS_EN
    ,
    output logic [15:0]       fill_count,
    output logic [15:0]       wb_count
`endif
);

    fill_state_t state_reg;
    fill_state_t state_next;

    logic              cnt_load;
    logic              cnt_zero;
    logic              accept;
    logic              capture;
    logic              wb_done;
    logic              fill_done;

    logic [IDX_W-1:0]  data_requested_reg;
    logic [IDX_W-1:0]  where_to_write_reg;
    logic [LINE_W-1:0] data_to_write_reg;
    logic [LINE_W-1:0] resp_data_reg;
    logic [ADDR_W-1:0] resp_addr_reg;

    mem_lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (lat_load(MEM_LATENCY)),
        .zero     (cnt_zero)
    );

    assign wb_done   = (state_reg == WB)   && cnt_zero;
    assign fill_done = (state_reg == FILL) && cnt_zero;

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cache.req_valid) begin
                    accept     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = cache.req_wb ? WB : FILL;
                end
            end
            WB: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (cache.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            data_requested_reg <= '0;
            where_to_write_reg <= '0;
            data_to_write_reg  <= '0;
            resp_data_reg      <= '0;
            resp_addr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // RAM indices are captured once so they stay stable for the
                // whole WB/FILL hold window regardless of the request bus.
                data_requested_reg <= {(IDX_W-2)'(cache.req_addr >> 4), 2'b00};
                where_to_write_reg <= IDX_W'(cache.req_wb_addr >> 4);
                data_to_write_reg  <= cache.req_wb_data;
                resp_addr_reg      <= {cache.req_addr[ADDR_W-1:4], 4'h0};
            end
            if (capture) begin
                resp_data_reg <= data_returned;
            end
        end
    end

    // Control outputs are gated by reset so they are inactive from the very
    // first reset cycle, and an aborted WB can never emit a write pulse.
    assign cache.req_ready  = (state_reg == IDLE) && !reset;
    assign cache.resp_valid = (state_reg == RESP) && !reset;
    assign write_to_mem     = wb_done && !reset;

    assign cache.resp_data  = resp_data_reg;
    assign cache.resp_addr  = resp_addr_reg;
    assign data_requested   = data_requested_reg;
    assign where_to_write   = where_to_write_reg;
    assign data_to_write    = data_to_write_reg;

`ifdef MEM_FILL_STATS_EN
    logic [1:0] stat_inc;
    assign stat_inc[0] = fill_done;
    assign stat_inc[1] = wb_done;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign fill_count = g_stat[0].cnt_reg;
    assign wb_count   = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_fill_ctrl
// Directed scoreboard bench for mem_fill_ctrl (MEM_LATENCY = 4). Stimulus
// pushes the hand-computed expected response into exp_q; a negedge monitor
// follows each accepted request and checks RAM-side timing and the response.
// ---------------------------------------------------------------------------
module tb_mem_fill_ctrl;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [19:0]  data_requested;
    logic [19:0]  where_to_write;
    logic [127:0] data_to_write;
    logic         write_to_mem;
    logic [127:0] data_returned;
`ifdef MEM_FILL_STATS_EN
    logic [15:0]  fill_count;
    logic [15:0]  wb_count;
`endif

    mem_fill_ctrl_if #(.ADDR_W(20), .LINE_W(128)) bus ();

    mem_fill_ctrl #(.MEM_LATENCY(L), .ADDR_W(20), .LINE_W(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .cache          (bus),
        .data_requested (data_requested),
        .where_to_write (where_to_write),
        .data_to_write  (data_to_write),
        .write_to_mem   (write_to_mem),
        .data_returned  (data_returned)
`ifdef MEM_FILL_STATS_EN
        ,
        .fill_count     (fill_count),
        .wb_count       (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word i starts as A000_0000 | i (re-initialised during reset).
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
        end else if (write_to_mem) begin
            for (int k = 0; k < 4; k++) mem[{where_to_write[5:0], 2'(k)}] <= data_to_write[32*k +: 32];
        end
    end
    always_comb begin
        data_returned = '0;
        for (int k = 0; k < 4; k++) data_returned[32*k +: 32] = mem[{data_requested[7:2], 2'(k)}];
    end

    typedef struct {
        logic [19:0]  rsp_addr;
        logic [19:0]  dreq;
        logic [19:0]  wtw;
        logic [127:0] wdata;
        logic [127:0] data;
        logic         wb;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic in_flight = 1'b0;
    logic seen_v    = 1'b0;
    int   acc_cyc   = 0;

    always @(negedge clk) begin
        exp_t h;
        int   off;
        if (reset) begin
            if (in_flight) begin
                void'(exp_q.pop_front());
                in_flight = 1'b0;
            end
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_write_to_mem", write_to_mem, 0);
        end else if (!in_flight) begin
            chk("idle_write_to_mem", write_to_mem, 0);
            chk("idle_resp_valid", bus.resp_valid, 0);
            if (bus.req_valid && bus.req_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_accept: got accept expected none (cycle %0d)", cyc);
                end else begin
                    in_flight = 1'b1;
                    seen_v    = 1'b0;
                    acc_cyc   = cyc;
                end
            end
        end else begin
            h   = exp_q[0];
            off = cyc - acc_cyc;
            chk("busy_req_ready", bus.req_ready, 0);
            chk("write_pulse", write_to_mem, (h.wb && off == L));
            if (h.wb && off <= L) begin
                chk("where_to_write", where_to_write, h.wtw);
                chk("data_to_write", data_to_write, h.wdata);
            end
            if (off > (h.wb ? L : 0) && off <= (h.wb ? 2*L : L)) begin
                chk("data_requested", data_requested, h.dreq);
            end
            if (seen_v) chk("resp_valid_hold", bus.resp_valid, 1);
            if (bus.resp_valid) begin
                if (!seen_v) chk("latency", off, h.lat);
                seen_v = 1'b1;
                chk("resp_data", bus.resp_data, h.data);
                chk("resp_addr", bus.resp_addr, h.rsp_addr);
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    in_flight = 1'b0;
                end
            end else if (off > 60) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_timeout: got no resp_valid expected one within %0d cycles", 60);
                void'(exp_q.pop_front());
                in_flight = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [19:0] e_addr, input logic [19:0] e_dreq, input logic wb,
                            input logic [19:0] e_wtw, input logic [127:0] wd,
                            input logic [127:0] e_data, input int lat);
        exp_t e;
        e.rsp_addr = e_addr;
        e.dreq     = e_dreq;
        e.wb       = wb;
        e.wtw      = e_wtw;
        e.wdata    = wd;
        e.data     = e_data;
        e.lat      = lat;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [19:0] a, input logic wb, input logic [19:0] wa,
                        input logic [127:0] wd, input logic [19:0] e_addr, input logic [19:0] e_dreq,
                        input logic [19:0] e_wtw, input logic [127:0] e_data, input int lat);
        logic got;
        push_exp(e_addr, e_dreq, wb, e_wtw, wd, e_data, lat);
        @(posedge clk); #1;
        bus.req_addr    = a;
        bus.req_wb      = wb;
        bus.req_wb_addr = wa;
        bus.req_wb_data = wd;
        bus.req_valid   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", got, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int sz;
        sz = 1;
        for (int i = 0; i < 100 && sz != 0; i++) begin
            @(negedge clk);
            sz = exp_q.size();
        end
        if (sz != 0) chk("drain_timeout", sz, 0);
    endtask

    localparam logic [127:0] D1  = 128'hA0000013_A0000012_A0000011_A0000010;
    localparam logic [127:0] D2  = 128'hA0000023_A0000022_A0000021_A0000020;
    localparam logic [127:0] D5  = 128'hA0000033_A0000032_A0000031_A0000030;
    localparam logic [127:0] D7  = 128'hA0000003_A0000002_A0000001_A0000000;
    localparam logic [127:0] D8  = 128'hA0000053_A0000052_A0000051_A0000050;
    localparam logic [127:0] WD2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] WD3 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] WD6 = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] WD8 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wb      = 1'b0;
        bus.req_wb_addr = '0;
        bus.req_wb_data = '0;
        bus.resp_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_addr", bus.resp_addr, 0);
        chk("rst_data_requested", data_requested, 0);
        chk("rst_where_to_write", where_to_write, 0);
        chk("rst_data_to_write", data_to_write, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1);

        // Plain fill, writeback + fill, writeback to the same line, unaligned addr
        send(20'h00040, 1'b0, 20'h0, '0,  20'h00040, 20'h00010, 20'h0,     D1,  L+1);
        wait_done();
        send(20'h00080, 1'b1, 20'h00100, WD2, 20'h00080, 20'h00020, 20'h00010, D2, 2*L+1);
        wait_done();
        send(20'h00100, 1'b1, 20'h00100, WD3, 20'h00100, 20'h00040, 20'h00010, WD3, 2*L+1);
        wait_done();
        send(20'h0004C, 1'b0, 20'h0, '0,  20'h00040, 20'h00010, 20'h0,     D1,  L+1);
        wait_done();

        // Response back-pressure with a competing request, then back-to-back accept
        bus.resp_ready = 1'b0;
        send(20'h000C0, 1'b0, 20'h0, '0,  20'h000C0, 20'h00030, 20'h0,     D5,  L+1);
        for (int i = 0; i < 40 && !bus.resp_valid; i++) @(negedge clk);
        chk("hold_resp_valid_seen", bus.resp_valid, 1);
        push_exp(20'h00100, 20'h00040, 1'b0, 20'h0, '0, WD3, L+1);
        @(posedge clk); #1;
        bus.req_addr  = 20'h00104;
        bus.req_wb    = 1'b0;
        bus.req_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_resp_valid", bus.resp_valid, 1);
        @(negedge clk);
        chk("b2b_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_done();

        // Reset on the second WB cycle aborts the operation
        send(20'h00000, 1'b1, 20'h00200, WD6, 20'h00000, 20'h00000, 20'h00020, '0, 2*L+1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", bus.req_ready, 1);
        repeat (12) @(negedge clk);
        chk("abort_discarded", exp_q.size(), 0);

        // Three fills after reset, one with writeback (read back the written line)
        send(20'h00000, 1'b0, 20'h0, '0,  20'h00000, 20'h00000, 20'h0,     D7,  L+1);
        wait_done();
        send(20'h00140, 1'b1, 20'h00180, WD8, 20'h00140, 20'h00050, 20'h00018, D8, 2*L+1);
        wait_done();
        send(20'h00180, 1'b0, 20'h0, '0,  20'h00180, 20'h00060, 20'h0,     WD8, L+1);
        wait_done();
`ifdef MEM_FILL_STATS_EN
        chk("fill_count", fill_count, 3);
        chk("wb_count", wb_count, 1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning cycles the RAM address/data is held before a read is sampled or a write is retired; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 20, meaning the physical byte-address width.
REQ-003 SHALL have parameter LINE_W, default 128, meaning the cache line width (4 x 32-bit words).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a cache miss request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 SHALL have port req_addr, input, ADDR_W bits: line-aligned byte address to fill; bits [3:0] ignored.
REQ-009 SHALL have port req_wb, input, 1 bit: a dirty victim must be written back before the fill.
REQ-010 SHALL have port req_wb_addr, input, ADDR_W bits: line-aligned byte address of the victim.
REQ-011 SHALL have port req_wb_data, input, LINE_W bits: victim line data.
REQ-012 SHALL have port resp_valid, output, 1 bit: the fill line is available.
REQ-013 SHALL have port resp_ready, input, 1 bit: the cache consumes the response.
REQ-014 SHALL have port resp_data, output, LINE_W bits: filled line, word 0 in bits [31:0].
REQ-015 SHALL have port resp_addr, output, ADDR_W bits: echo of the accepted req_addr with bits [3:0] cleared.
REQ-016 SHALL have port data_requested, output, 20 bits: RAM read word index, equal to req_addr>>2 with bits [1:0] cleared.
REQ-017 SHALL have port where_to_write, output, 20 bits: RAM write line index, equal to req_wb_addr>>4.
REQ-018 SHALL have port data_to_write, output, LINE_W bits: write data to the RAM.
REQ-019 SHALL have port write_to_mem, output, 1 bit: RAM write enable.
REQ-020 SHALL have port data_returned, input, LINE_W bits: RAM read data.

Function
REQ-021 SHALL implement the FSM states IDLE, WB, FILL and RESP.
REQ-022 SHALL, in IDLE, drive req_ready=1, and on req_valid&req_ready latch all req_* fields; next state is WB if req_wb=1, else FILL.
REQ-023 SHALL drive req_ready=0 in every state other than IDLE.
REQ-024 SHALL, in WB, hold where_to_write and data_to_write stable for MEM_LATENCY cycles, with write_to_mem=1 only in the last of those cycles (one-cycle pulse), then go to FILL.
REQ-025 SHALL, in FILL, hold data_requested stable for MEM_LATENCY cycles, register data_returned into resp_data on the last cycle, then go to RESP.
REQ-026 SHALL, in RESP, hold resp_valid=1 with resp_data and resp_addr stable until resp_ready=1; resp_valid&resp_ready returns the FSM to IDLE.
REQ-027 SHALL use a 4-bit down-counter loaded with MEM_LATENCY-1 on entry to WB or FILL; the state exits when the counter is 0.
REQ-028 SHALL give a request-accepted-to-resp_valid latency of MEM_LATENCY+1 cycles without writeback and 2*MEM_LATENCY+1 cycles with writeback.
REQ-029 SHALL NOT accept a new request in the same cycle as the response handshake; it is accepted no earlier than the following IDLE cycle.
REQ-030 SHALL write back and then fill when req_wb_addr equals req_addr, and the fill SHALL return the written-back data.
REQ-031 SHALL keep write_to_mem=0 at all times outside WB.

Reset
REQ-032 SHALL, while reset=1, enter IDLE, clear the counter, and drive req_ready=0, resp_valid=0, write_to_mem=0 and resp_data/resp_addr/data_requested/where_to_write/data_to_write=0.
REQ-033 SHALL, on reset asserted in WB or FILL, abort the operation with no write_to_mem pulse and no response; a latched request is discarded.
REQ-034 SHALL assert req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-035 SHALL, when MEM_FILL_STATS_EN is defined, add 16-bit outputs fill_count and wb_count that increment on each FILL exit and WB exit, saturate at 16'hFFFF, and are cleared by reset.
REQ-036 SHALL, when MEM_FILL_STATS_EN is undefined, have neither port nor counter logic.

Structure
REQ-037 SHALL take ADDR_W/LINE_W defaults and the state enum (IDLE, WB, FILL, RESP) from a shared package mem_pkg.
REQ-038 SHALL implement the latency down-counter as sub-module mem_lat_counter (inputs load, load_val; output zero).

Verification
REQ-039 SHALL verify, with MEM_LATENCY=4 and req_addr=0x00040, req_wb=0: data_requested=0x00010 for 4 cycles, resp_valid 5 cycles after acceptance, resp_data={mem[19],mem[18],mem[17],mem[16]}.
REQ-040 SHALL verify, with req_wb=1, req_wb_addr=0x00100, req_wb_data=128'hDEAD...: where_to_write=0x00010, a one-cycle write_to_mem pulse on cycle 4, resp_valid on cycle 9.
REQ-041 SHALL verify, with resp_ready held 0 for 6 cycles: resp_valid and resp_data stable throughout, req_ready=0, and a new req_valid not accepted.
REQ-042 SHALL verify that reset asserted on cycle 2 of WB produces no write_to_mem pulse, no resp_valid, and req_ready=1 after reset deasserts.
REQ-043 SHALL verify back-to-back requests: the second is accepted exactly one cycle after the response handshake.
REQ-044 SHALL verify, with MEM_FILL_STATS_EN defined and 3 fills, 1 of them with writeback: fill_count=3, wb_count=1.
